// File: rtl/alu_flags_reg_n.sv
// alu_flags_reg_n: registered N-bit ALU stage with NZCV flags and a per-op flag-write enable.
// Define ALU_FLAGS_COND_EN to gate execution on an ARM condition code; otherwise every op executes.
module alu_flags_reg_n #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [2:0]   alu_ctrl,
  input  logic         set_flags,
  input  logic [3:0]   cond,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         out_exec,
  output logic [3:0]   flags
);
  logic         valid_q, valid_d, exec_q, exec_d;
  logic         accept, arith, sub, cin, pass;
  logic [N-1:0] result_q, result_d, op_b, res;
  logic [N:0]   sum;
  logic [3:0]   flags_q, flags_d, nzcv;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign arith    = alu_ctrl inside {3'b000, 3'b001, 3'b101, 3'b110};
  assign sub      = alu_ctrl == 3'b001 || alu_ctrl == 3'b110;

  // flags_q is {N,Z,C,V}; ADC/SBC take the stored carry, SUB forces carry-in for two's complement
  always_comb begin
    op_b = sub ? ~b : b;
    cin  = alu_ctrl[2] ? flags_q[1] : sub;
    sum  = {1'b0, a} + {1'b0, op_b} + {{N{1'b0}}, cin};
    res  = alu_ctrl == 3'b010 ? a & b :
           alu_ctrl == 3'b011 ? a | b :
           alu_ctrl == 3'b100 ? a ^ b :
           alu_ctrl == 3'b111 ? b : sum[N-1:0];
    nzcv = {res[N-1], res == '0, arith && sum[N],
            arith && a[N-1] == op_b[N-1] && sum[N-1] != a[N-1]};
  end

`ifdef ALU_FLAGS_COND_EN
  logic base;
  // even codes test the base predicate, odd codes its inverse; 111x is always
  always_comb begin
    case (cond[3:1])
      3'd0:    base = flags_q[2];
      3'd1:    base = flags_q[1];
      3'd2:    base = flags_q[3];
      3'd3:    base = flags_q[0];
      3'd4:    base = flags_q[1] && !flags_q[2];
      3'd5:    base = flags_q[3] == flags_q[0];
      3'd6:    base = !flags_q[2] && flags_q[3] == flags_q[0];
      default: base = 1'b1;
    endcase
    pass = cond[3:1] == 3'd7 || (base ^ cond[0]);
  end
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign pass        = 1'b1;
`endif

  always_comb begin
    valid_d  = accept || (valid_q && !out_ready);
    result_d = accept ? (pass ? res : '0) : result_q;
    exec_d   = accept ? pass : exec_q;
    flags_d  = accept && pass && set_flags ? nzcv : flags_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      exec_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      valid_q  <= valid_d;
      exec_q   <= exec_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign result    = result_q;
  assign out_exec  = exec_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_alu_flags_reg_n.sv
// tb_alu_flags_reg_n: directed and randomized checks of alu_flags_reg_n (N=4) against an
// integer-arithmetic reference model; follows ALU_FLAGS_COND_EN the same way the design does.
module tb_alu_flags_reg_n;
`ifdef ALU_FLAGS_COND_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, iv = 1'b0, ordy = 1'b0, sf = 1'b0;
  logic [3:0] a_i = '0, b_i = '0, cc = 4'd14;
  logic [2:0] op = '0;
  logic       in_ready, out_valid, out_exec;
  logic [3:0] result, flags;
  int         checks = 0, errors = 0;
  bit         m_ov = 0, m_exec = 0;
  logic [3:0] m_res = '0, m_flags = '0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a, b;
    bit         sf;
    logic [3:0] cc, r;
    bit         ex;
    logic [3:0] f;
  } row_t;
  row_t plan [14];

  alu_flags_reg_n #(.N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(in_ready), .a(a_i), .b(b_i),
    .alu_ctrl(op), .set_flags(sf), .cond(cc), .out_valid(out_valid), .out_ready(ordy),
    .result(result), .out_exec(out_exec), .flags(flags)
  );

  always #5 clk = ~clk;

  // {N,Z,C,V, result} from signed/unsigned integer arithmetic
  function automatic logic [7:0] ref_alu(int ua, int ub, int o, int c);
    int sa, sb, u, s;
    bit ar, cf, vf;
    logic [3:0] r, la, lb;
    sa = ua > 7 ? ua - 16 : ua;
    sb = ub > 7 ? ub - 16 : ub;
    la = 4'(ua);
    lb = 4'(ub);
    ar = 1;
    u = 0;
    s = 0;
    case (o)
      0: begin u = ua + ub; s = sa + sb; end
      1: begin u = ua - ub; s = sa - sb; end
      5: begin u = ua + ub + c; s = sa + sb + c; end
      6: begin u = ua - ub - 1 + c; s = sa - sb - 1 + c; end
      default: ar = 0;
    endcase
    cf = ar && ((o == 0 || o == 5) ? u > 15 : u >= 0);
    vf = ar && (s < -8 || s > 7);
    r = ar ? 4'((u + 32) % 16) : o == 2 ? la & lb : o == 3 ? la | lb : o == 4 ? la ^ lb : lb;
    return {r[3], r == 4'd0, cf, vf, r};
  endfunction

  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, k, v, ok;
    {n, z, k, v} = f;
    case (c)
      0: ok = z;            1: ok = !z;
      2: ok = k;            3: ok = !k;
      4: ok = n;            5: ok = !n;
      6: ok = v;            7: ok = !v;
      8: ok = k && !z;      9: ok = !k || z;
      10: ok = n == v;      11: ok = n != v;
      12: ok = !z && n == v; 13: ok = z || n != v;
      default: ok = 1;
    endcase
    return !COND_EN || ok;
  endfunction

  task automatic apply(bit v, logic [3:0] x, logic [3:0] y, logic [2:0] o, bit s, logic [3:0] c, bit r);
    iv = v; a_i = x; b_i = y; op = o; sf = s; cc = c; ordy = r;
    #1;
  endtask

  task automatic tick();
    logic [7:0] r;
    bit p;
    if (iv && (!m_ov || ordy)) begin
      r = ref_alu(int'(a_i), int'(b_i), int'(op), int'(m_flags[1]));
      p = cond_ok(cc, m_flags);
      m_res = p ? r[3:0] : 4'd0;
      m_exec = p;
      if (p && sf) m_flags = r[7:4];
      m_ov = 1;
    end else if (ordy) m_ov = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b want 0", out_valid); end
    if (result !== 4'd0) begin errors++; $display("FAIL reset result got %h want 0", result); end
    if (out_exec !== 1'b0) begin errors++; $display("FAIL reset out_exec got %b want 0", out_exec); end
    if (flags !== 4'd0) begin errors++; $display("FAIL reset flags got %b want 0000", flags); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b want 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_plan();
    plan = '{
      '{3'd0, 4'd7, 4'd1, 1, 4'd14, 4'd8, 1, 4'b1001},
      '{3'd1, 4'd3, 4'd3, 1, 4'd14, 4'd0, 1, 4'b0110},
      '{3'd0, 4'd1, 4'd1, 0, 4'd0, 4'd2, 1, 4'b0110},
      '{3'd0, 4'd1, 4'd1, 0, 4'd1, COND_EN ? 4'd0 : 4'd2, !COND_EN, 4'b0110},
      '{3'd5, 4'd1, 4'd1, 0, 4'd14, 4'd3, 1, 4'b0110},
      '{3'd6, 4'd5, 4'd2, 0, 4'd14, 4'd3, 1, 4'b0110},
      '{3'd2, 4'd12, 4'd10, 1, 4'd14, 4'd8, 1, 4'b1000},
      '{3'd1, 4'd3, 4'd3, 1, 4'd14, 4'd0, 1, 4'b0110},
      '{3'd2, 4'd12, 4'd10, 0, 4'd14, 4'd8, 1, 4'b0110},
      '{3'd3, 4'd5, 4'd10, 1, 4'd15, 4'd15, 1, 4'b1000},
      '{3'd6, 4'd2, 4'd5, 1, 4'd14, 4'd12, 1, 4'b1000},
      '{3'd4, 4'd6, 4'd6, 1, 4'd14, 4'd0, 1, 4'b0100},
      '{3'd7, 4'd3, 4'd9, 1, 4'd14, 4'd9, 1, 4'b1000},
      '{3'd1, 4'd8, 4'd1, 1, 4'd14, 4'd7, 1, 4'b0011}
    };
    foreach (plan[i]) begin
      apply(1, plan[i].a, plan[i].b, plan[i].op, plan[i].sf, plan[i].cc, 1);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL plan[%0d] in_ready got %b want 1", i, in_ready); end
      tick();
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL plan[%0d] out_valid got %b want 1", i, out_valid); end
      if (result !== plan[i].r) begin errors++; $display("FAIL plan[%0d] result got %h want %h", i, result, plan[i].r); end
      if (out_exec !== plan[i].ex) begin errors++; $display("FAIL plan[%0d] out_exec got %b want %b", i, out_exec, plan[i].ex); end
      if (flags !== plan[i].f) begin errors++; $display("FAIL plan[%0d] flags got %b want %b", i, flags, plan[i].f); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held_r, held_f;
    held_r = result;
    held_f = flags;
    for (int i = 0; i < 3; i++) begin
      apply(1, 4'($urandom), 4'($urandom), 3'($urandom), 1, 4'd14, 0);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL stall%0d in_ready got %b want 0", i, in_ready); end
      tick();
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL stall%0d out_valid got %b want 1", i, out_valid); end
      if (result !== held_r) begin errors++; $display("FAIL stall%0d result got %h want %h", i, result, held_r); end
      if (flags !== held_f) begin errors++; $display("FAIL stall%0d flags got %b want %b", i, flags, held_f); end
    end
    apply(1, 4'd2, 4'd3, 3'd0, 1, 4'd14, 1);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL drain in_ready got %b want 1", in_ready); end
    tick();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL drain out_valid got %b want 1", out_valid); end
    if (result !== m_res || result !== 4'd5) begin errors++; $display("FAIL drain result got %h want %h", result, m_res); end
    if (flags !== m_flags) begin errors++; $display("FAIL drain flags got %b want %b", flags, m_flags); end
  endtask

  task automatic test_random();
    bit er;
    for (int i = 0; i < 400; i++) begin
      er = !m_ov || ($urandom_range(0, 9) < 7);
      apply($urandom_range(0, 9) < 7, 4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom),
            4'($urandom), er);
      checks++;
      if (in_ready !== (!m_ov || ordy)) begin errors++; $display("FAIL rand%0d in_ready got %b want %b", i, in_ready, !m_ov || ordy); end
      tick();
      checks += 4;
      if (out_valid !== m_ov) begin errors++; $display("FAIL rand%0d out_valid got %b want %b", i, out_valid, m_ov); end
      if (result !== m_res) begin errors++; $display("FAIL rand%0d result got %h want %h", i, result, m_res); end
      if (out_exec !== m_exec) begin errors++; $display("FAIL rand%0d out_exec got %b want %b", i, out_exec, m_exec); end
      if (flags !== m_flags) begin errors++; $display("FAIL rand%0d flags got %b want %b", i, flags, m_flags); end
    end
  endtask

  task automatic test_async_reset();
    apply(0, 4'd0, 4'd0, 3'd0, 0, 4'd14, 1);
    tick();
    apply(1, 4'd7, 4'd1, 3'd0, 1, 4'd14, 0);
    tick();
    checks += 2;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre out_valid got %b want 1", out_valid); end
    if (flags !== 4'b1001) begin errors++; $display("FAIL arst_pre flags got %b want 1001", flags); end
    apply(0, 4'd0, 4'd0, 3'd0, 0, 4'd14, 0);
    #1 rst_n = 1'b0;
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst out_valid got %b want 0", out_valid); end
    if (result !== 4'd0) begin errors++; $display("FAIL arst result got %h want 0", result); end
    if (flags !== 4'd0) begin errors++; $display("FAIL arst flags got %b want 0000", flags); end
    if (out_exec !== 1'b0) begin errors++; $display("FAIL arst out_exec got %b want 0", out_exec); end
    m_ov = 0; m_res = '0; m_exec = 0; m_flags = '0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 4'd0, 4'd0, 3'd0, 0, 4'd14, 1);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_post out_valid got %b want 0", out_valid); end
    apply(1, 4'd3, 4'd3, 3'd1, 1, 4'd14, 1);
    tick();
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_acc out_valid got %b want 1", out_valid); end
    if (result !== 4'd0 || out_exec !== 1'b1) begin errors++; $display("FAIL arst_acc result/exec got %h/%b want 0/1", result, out_exec); end
    if (flags !== 4'b0110) begin errors++; $display("FAIL arst_acc flags got %b want 0110", flags); end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
